// File: rtl/spi_slave_rx_mode3.sv
// -----------------------------------------------------------------------------
// spi_slave_rx_mode3
//
// Purpose:
//   SPI mode-3 slave receiver (CPOL=1, CPHA=1, MSB first). It oversamples CS_n,
//   SCLK and MOSI on the local system clock and shifts MOSI in on each
//   synchronised SCLK rising edge. Each completed DATA_WIDTH-bit word is
//   presented with a one-cycle valid strobe. A frame cut short by CS_n rising
//   mid-word produces a one-cycle error strobe, and the partial word is dropped.
//
// Ports:
//   In_clk        system clock
//   In_rst_n      asynchronous active-low reset
//   In_spi_cs_n   chip select from master (async, active-low)
//   In_spi_sclk   SPI clock from master (async, idles high)
//   In_spi_mosi   serial data from master (async, changes on SCLK fall)
//   Out_rx_data   last completed word, held until the next one completes
//   Out_rx_valid  one-cycle pulse: Out_rx_data is new this cycle
//   Out_rx_busy   high while a frame is in progress (synchronised CS_n low)
//   Out_rx_err    one-cycle pulse: CS_n rose with a partial word pending
// -----------------------------------------------------------------------------
module spi_slave_rx_mode3 #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  In_clk,
  input  logic                  In_rst_n,
  input  logic                  In_spi_cs_n,
  input  logic                  In_spi_sclk,
  input  logic                  In_spi_mosi,
  output logic [DATA_WIDTH-1:0] Out_rx_data,
  output logic                  Out_rx_valid,
  output logic                  Out_rx_busy,
  output logic                  Out_rx_err
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Input synchronisers. The MSB of each vector is the synchronised value.
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;

  logic cs_s;
  logic sclk_s;
  logic mosi_s;
  logic sclk_rise;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  always_ff @(posedge In_clk or negedge In_rst_n) begin
    if (!In_rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b1;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], In_spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], In_spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], In_spi_mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  // Only rising edges sample data in mode 3; falling edges are ignored.
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!cs_s) begin
          state_d = RECV;
        end
      end

      RECV: begin
        // CS_n release is checked first so that an SCLK edge seen in the
        // same cycle is discarded and a just-completing word counts as
        // truncated rather than valid.
        if (cs_s) begin
          state_d = IDLE;
          cnt_d   = '0;
          shift_d = '0;
          if (cnt_q != '0) begin
            err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s};
          if (cnt_q == LAST_BIT) begin
            data_d  = {shift_q[DATA_WIDTH-2:0], mosi_s};
            valid_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge In_clk or negedge In_rst_n) begin
    if (!In_rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign Out_rx_data  = data_q;
  assign Out_rx_valid = valid_q;
  assign Out_rx_err   = err_q;
  assign Out_rx_busy  = (state_q == RECV);

endmodule

// File: tb/tb_spi_slave_rx_mode3.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx_mode3
//
// Directed bench for spi_slave_rx_mode3: drives mode-3 SPI frames and checks
// received words, error pulses and busy against hand-computed values.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx_mode3;

  // 50 MHz system clock. SCLK runs faster than the nominal 50 kHz to keep the
  // run short; each SCLK phase is still several times the synchroniser depth.
  localparam int HALF = 8;

  logic       clk;
  logic       rst_n;
  logic       cs_n;
  logic       sclk;
  logic       mosi;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] rx_q[$];
  int         err_cnt  = 0;
  int         both_cnt = 0;

  int vbase;
  int ebase;

  spi_slave_rx_mode3 #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .In_clk      (clk),
    .In_rst_n    (rst_n),
    .In_spi_cs_n (cs_n),
    .In_spi_sclk (sclk),
    .In_spi_mosi (mosi),
    .Out_rx_data (rx_data),
    .Out_rx_valid(rx_valid),
    .Out_rx_busy (rx_busy),
    .Out_rx_err  (rx_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rx_q.push_back(rx_data);
        $display("rx word %02h", rx_data);
      end
      if (rx_err) begin
        err_cnt++;
        $display("rx truncated-frame pulse");
      end
      if (rx_valid && rx_err) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-3 bit: MOSI changes after the falling edge, sampled on the rise.
  task automatic spi_bit(input logic b);
    sclk = 1'b0;
    mosi = b;
    wait_cyc(HALF);
    sclk = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic send_bits(input logic [7:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) spi_bit(word[7-i]);
  endtask

  task automatic cs_fall();
    @(negedge clk);
    cs_n = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic cs_rise();
    wait_cyc(HALF);
    cs_n = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic frame(input logic [7:0] word, input int nbits);
    $display("tx frame %02h, %0d bits", word, nbits);
    cs_fall();
    send_bits(word, nbits);
    cs_rise();
  endtask

  task automatic mark();
    vbase = rx_q.size();
    ebase = err_cnt;
  endtask

  initial begin
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b1;
    mosi  = 1'b0;
    vbase = 0;
    ebase = 0;

    // Reset values.
    wait_cyc(3);
    check("reset_data", 32'(rx_data), 32'h0);
    check("reset_valid", 32'(rx_valid), 32'h0);
    check("reset_busy", 32'(rx_busy), 32'h0);
    check("reset_err", 32'(rx_err), 32'h0);
    rst_n = 1'b1;
    wait_cyc(4);

    // Single word 8'h12, busy follows CS_n through the synchroniser.
    mark();
    @(negedge clk);
    cs_n = 1'b0;
    wait_cyc(1);
    check("t1_busy_delayed", 32'(rx_busy), 32'h0);
    wait_cyc(HALF);
    check("t1_busy_high", 32'(rx_busy), 32'h1);
    send_bits(8'h12, 8);
    cs_rise();
    check("t1_valid_count", 32'(rx_q.size() - vbase), 32'd1);
    check("t1_data", 32'(rx_q[vbase]), 32'h12);
    check("t1_err", 32'(err_cnt - ebase), 32'd0);
    check("t1_busy_low", 32'(rx_busy), 32'h0);

    // Two words in one frame.
    mark();
    cs_fall();
    send_bits(8'h12, 8);
    check("t2_busy_mid", 32'(rx_busy), 32'h1);
    send_bits(8'h55, 8);
    cs_rise();
    check("t2_valid_count", 32'(rx_q.size() - vbase), 32'd2);
    check("t2_word0", 32'(rx_q[vbase]), 32'h12);
    check("t2_word1", 32'(rx_q[vbase+1]), 32'h55);
    check("t2_err", 32'(err_cnt - ebase), 32'd0);

    // Truncated frame: 5 bits of 8'hA5, then a full 8'hA5.
    mark();
    frame(8'hA5, 5);
    check("t3_err_count", 32'(err_cnt - ebase), 32'd1);
    check("t3_no_valid", 32'(rx_q.size() - vbase), 32'd0);
    check("t3_data_held", 32'(rx_data), 32'h55);
    mark();
    frame(8'hA5, 8);
    check("t3_valid_count", 32'(rx_q.size() - vbase), 32'd1);
    check("t3_data", 32'(rx_q[vbase]), 32'hA5);
    check("t3_err_after", 32'(err_cnt - ebase), 32'd0);

    // SCLK toggling with CS_n high is ignored.
    mark();
    send_bits(8'hFF, 8);
    check("t4_busy", 32'(rx_busy), 32'h0);
    send_bits(8'h0F, 8);
    wait_cyc(HALF);
    check("t4_no_valid", 32'(rx_q.size() - vbase), 32'd0);
    check("t4_no_err", 32'(err_cnt - ebase), 32'd0);
    // A following frame must start at bit 0.
    frame(8'hC3, 8);
    check("t4_after_count", 32'(rx_q.size() - vbase), 32'd1);
    check("t4_after_data", 32'(rx_q[vbase]), 32'hC3);

    // Reset mid-word, then a full 8'h3C.
    cs_fall();
    send_bits(8'h3C, 4);
    rst_n = 1'b0;
    wait_cyc(1);
    check("t5_rst_data", 32'(rx_data), 32'h0);
    check("t5_rst_valid", 32'(rx_valid), 32'h0);
    check("t5_rst_busy", 32'(rx_busy), 32'h0);
    check("t5_rst_err", 32'(rx_err), 32'h0);
    cs_n = 1'b1;
    sclk = 1'b1;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(4);
    mark();
    frame(8'h3C, 8);
    check("t5_valid_count", 32'(rx_q.size() - vbase), 32'd1);
    check("t5_data", 32'(rx_q[vbase]), 32'h3C);
    check("t5_err", 32'(err_cnt - ebase), 32'd0);

    // Boundary words back to back.
    mark();
    frame(8'hFF, 8);
    frame(8'h00, 8);
    frame(8'h80, 8);
    frame(8'h01, 8);
    check("t6_valid_count", 32'(rx_q.size() - vbase), 32'd4);
    check("t6_ff", 32'(rx_q[vbase]), 32'hFF);
    check("t6_00", 32'(rx_q[vbase+1]), 32'h00);
    check("t6_80", 32'(rx_q[vbase+2]), 32'h80);
    check("t6_01", 32'(rx_q[vbase+3]), 32'h01);
    check("t6_err", 32'(err_cnt - ebase), 32'd0);

    check("valid_err_overlap", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
